// File: rtl/uart_ddr_pkg.sv
// Shared definitions for the UART-to-DDR3 write path.
package uart_ddr_pkg;

   // Scheduler FSM: gather words, then hold a burst request until acknowledged
   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_REQ     = 1'b1
   } sched_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BURST_LEN_W    = 9;

endpackage

// File: rtl/uart_ddr_wr_sched.sv
// Write scheduler between uart_receiver and the DDR3 write path.
// Forwards received words into the write FIFO, tracks how many are buffered
// but not yet committed, and requests bursts into a linear ring of DDR.
// A partial burst is flushed once the UART has been idle long enough.
module uart_ddr_wr_sched
   import uart_ddr_pkg::*;
#(
   parameter int unsigned FIFO_WR_WIDTH = 32,
   parameter int unsigned BURST_WORDS   = 16,
   parameter int unsigned FIFO_DEPTH    = 512,
   parameter int unsigned ADDR_WIDTH    = 30,
   parameter int unsigned BASE_ADDR     = 0,
   parameter int unsigned END_ADDR      = 1048576,
   parameter int unsigned TIMEOUT_CYC   = 104160
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     word_valid,
   input  logic [FIFO_WR_WIDTH-1:0] word_data,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
   output logic                     wr_burst_req,
   output logic [ADDR_WIDTH-1:0]    wr_burst_addr,
   output logic [BURST_LEN_W-1:0]   wr_burst_len,
   input  logic                     wr_burst_ack,
   output logic                     overflow
);

   localparam int PEND_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam int SUM_W  = ADDR_WIDTH + 1;

   localparam logic [PEND_W-1:0]      BURST_PEND  = PEND_W'(BURST_WORDS);
   localparam logic [IDLE_W-1:0]      IDLE_MAX    = IDLE_W'(TIMEOUT_CYC);
   localparam logic [BURST_LEN_W-1:0] FULL_LEN    = BURST_LEN_W'(BURST_WORDS);
   localparam logic [SUM_W-1:0]       BURST_BYTES = SUM_W'(BURST_WORDS * BYTES_PER_WORD);
   localparam logic [SUM_W-1:0]       END_SUM     = SUM_W'(END_ADDR);
   localparam logic [ADDR_WIDTH-1:0]  BASE        = ADDR_WIDTH'(BASE_ADDR);

   sched_state_t                state, state_next;
   logic [PEND_W-1:0]           pending;
   logic [IDLE_W-1:0]           idle_cnt;
   logic                        accept;
   logic                        ack_take;
   logic                        issue;
   logic [BURST_LEN_W-1:0]      issue_len;
   logic [SUM_W-1:0]            addr_sum;
   logic [ADDR_WIDTH-1:0]       next_addr;

   assign accept       = word_valid & ~fifo_full;
   assign ack_take     = (state == ST_REQ) & wr_burst_ack;
   assign wr_burst_req = (state == ST_REQ);

   // Register the FIFO write one cycle after the strobe; a word that meets a full FIFO is dropped and flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         overflow     <= 1'b0;
      end else begin
         fifo_wr_en <= accept;
         if (accept)
            fifo_wr_data <= word_data;
         if (word_valid && fifo_full)
            overflow <= 1'b1;
      end
   end

   // Buffered-but-uncommitted word count; accept and ack may land in the same cycle
   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending + PEND_W'(accept) - (ack_take ? PEND_W'(wr_burst_len) : '0);
   end

   // Idle timer: restarts on any strobe or when nothing is buffered, saturates at the timeout
   always_ff @(posedge clk) begin
      if (rst)
         idle_cnt <= '0;
      else if (word_valid || (pending == '0))
         idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
         idle_cnt <= idle_cnt + 1'b1;
   end

   // Next burst address; wrap to the ring start if a full burst would no longer fit before the end
   always_comb begin
      addr_sum  = {1'b0, wr_burst_addr} + SUM_W'(wr_burst_len) * SUM_W'(BYTES_PER_WORD);
      next_addr = addr_sum[ADDR_WIDTH-1:0];
      if ((addr_sum + BURST_BYTES) > END_SUM)
         next_addr = BASE;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_COLLECT;
      else
         state <= state_next;
   end

   // Next-state logic: a full burst wins over a timeout flush
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      issue_len  = '0;
      case (state)
         ST_COLLECT: begin
            if (pending >= BURST_PEND) begin
               issue     = 1'b1;
               issue_len = FULL_LEN;
            end else if ((idle_cnt == IDLE_MAX) && (pending != '0)) begin
               issue     = 1'b1;
               issue_len = BURST_LEN_W'(pending);
            end
            if (issue)
               state_next = ST_REQ;
         end
         ST_REQ: begin
            if (wr_burst_ack)
               state_next = ST_COLLECT;
         end
         default: state_next = ST_COLLECT;
      endcase
   end

   // Latch the burst length at issue and advance the ring address when the burst completes
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_burst_addr <= BASE;
         wr_burst_len  <= '0;
      end else begin
         if (issue)
            wr_burst_len <= issue_len;
         if (ack_take)
            wr_burst_addr <= next_addr;
      end
   end

endmodule

// File: tb/tb_uart_ddr_wr_sched.sv
// Directed testbench for uart_ddr_wr_sched with a small ring and short timeout.
module tb_uart_ddr_wr_sched;

   localparam int TIMEOUT = 40;
   localparam int ENDA    = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        word_valid;
   logic [31:0] word_data;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [31:0] fifo_wr_data;
   logic        wr_burst_req;
   logic [29:0] wr_burst_addr;
   logic [8:0]  wr_burst_len;
   logic        wr_burst_ack;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int waited;

   uart_ddr_wr_sched #(
      .FIFO_WR_WIDTH(32),
      .BURST_WORDS(16),
      .FIFO_DEPTH(512),
      .ADDR_WIDTH(30),
      .BASE_ADDR(0),
      .END_ADDR(ENDA),
      .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .word_valid(word_valid),
      .word_data(word_data),
      .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .wr_burst_req(wr_burst_req),
      .wr_burst_addr(wr_burst_addr),
      .wr_burst_len(wr_burst_len),
      .wr_burst_ack(wr_burst_ack),
      .overflow(overflow)
   );

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive the UART-side inputs for the coming edge
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic f);
      word_valid = v;
      word_data  = d;
      fifo_full  = f;
   endtask

   // Synchronous reset held across two edges
   task automatic doReset();
      rst          = 1'b1;
      wr_burst_ack = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Back-to-back word strobes, optionally checking each forwarded write
   task automatic sendWords(input int n, input logic [31:0] base, input bit chk);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, base + 32'(i), 1'b0);
         tick();
         if (chk) begin
            checkOutput("fwd_en", {31'b0, fifo_wr_en}, 32'd1);
            checkOutput("fwd_data", fifo_wr_data, base + 32'(i));
         end
      end
      applyStimulus(1'b0, 32'h0, 1'b0);
   endtask

   // Bounded wait for the burst request; returns ticks taken or -1
   task automatic waitReq(input int max, output int n);
      n = -1;
      for (int k = 1; k <= max; k++) begin
         tick();
         if (wr_burst_req) begin
            n = k;
            break;
         end
      end
   endtask

   // One-cycle ack pulse
   task automatic pulseAck();
      wr_burst_ack = 1'b1;
      tick();
      wr_burst_ack = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      wr_burst_ack = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick();
      tick();
      $display("[TB] reset values");
      checkOutput("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
      checkOutput("rst_wr_data", fifo_wr_data, 32'd0);
      checkOutput("rst_req", {31'b0, wr_burst_req}, 32'd0);
      checkOutput("rst_addr", {2'b0, wr_burst_addr}, 32'd0);
      checkOutput("rst_len", {23'b0, wr_burst_len}, 32'd0);
      checkOutput("rst_ovf", {31'b0, overflow}, 32'd0);
      rst = 1'b0;

      $display("[TB] full burst of 16 words");
      sendWords(16, 32'h1, 1'b1);
      checkOutput("full_req_early", {31'b0, wr_burst_req}, 32'd0);
      tick();
      checkOutput("full_req", {31'b0, wr_burst_req}, 32'd1);
      checkOutput("full_addr", {2'b0, wr_burst_addr}, 32'd0);
      checkOutput("full_len", {23'b0, wr_burst_len}, 32'd16);
      pulseAck();
      checkOutput("full_req_fall", {31'b0, wr_burst_req}, 32'd0);
      checkOutput("full_pending", 32'(dut.pending), 32'd0);
      checkOutput("full_next_addr", {2'b0, wr_burst_addr}, 32'd64);

      $display("[TB] timeout flush of 5 words");
      doReset();
      sendWords(5, 32'h100, 1'b0);
      // first tick after the strobe already elapsed inside sendWords
      waitReq(TIMEOUT + 10, waited);
      checkOutput("tmo_latency", 32'(waited), 32'(TIMEOUT + 1));
      checkOutput("tmo_len", {23'b0, wr_burst_len}, 32'd5);
      checkOutput("tmo_addr", {2'b0, wr_burst_addr}, 32'd0);
      pulseAck();
      checkOutput("tmo_next_addr", {2'b0, wr_burst_addr}, 32'd20);
      checkOutput("tmo_pending", 32'(dut.pending), 32'd0);

      $display("[TB] words arriving during a request");
      doReset();
      sendWords(20, 32'h200, 1'b0);
      checkOutput("req20_req", {31'b0, wr_burst_req}, 32'd1);
      checkOutput("req20_pending", 32'(dut.pending), 32'd20);
      for (int i = 0; i < 100; i++) tick();
      checkOutput("req20_hold", {31'b0, wr_burst_req}, 32'd1);
      pulseAck();
      checkOutput("req20_after_pending", 32'(dut.pending), 32'd4);
      checkOutput("req20_after_addr", {2'b0, wr_burst_addr}, 32'd64);
      waitReq(TIMEOUT + 10, waited);
      checkOutput("req20_flush_wait", 32'(waited), 32'd1);
      checkOutput("req20_flush_len", {23'b0, wr_burst_len}, 32'd4);
      checkOutput("req20_flush_addr", {2'b0, wr_burst_addr}, 32'd64);
      pulseAck();
      checkOutput("req20_wrap_addr", {2'b0, wr_burst_addr}, 32'd0);

      $display("[TB] strobe coincident with ack");
      doReset();
      sendWords(16, 32'h300, 1'b0);
      waitReq(5, waited);
      checkOutput("coin_req", {31'b0, wr_burst_req}, 32'd1);
      applyStimulus(1'b1, 32'h3AA, 1'b0);
      wr_burst_ack = 1'b1;
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      wr_burst_ack = 1'b0;
      checkOutput("coin_pending", 32'(dut.pending), 32'd1);
      checkOutput("coin_wr_en", {31'b0, fifo_wr_en}, 32'd1);
      wr_burst_ack = 1'b1;
      tick();
      wr_burst_ack = 1'b0;
      checkOutput("stray_ack_pending", 32'(dut.pending), 32'd1);
      checkOutput("stray_ack_addr", {2'b0, wr_burst_addr}, 32'd64);

      $display("[TB] ring wrap");
      doReset();
      sendWords(16, 32'h400, 1'b0);
      waitReq(5, waited);
      checkOutput("ring1_addr", {2'b0, wr_burst_addr}, 32'd0);
      pulseAck();
      sendWords(16, 32'h500, 1'b0);
      waitReq(5, waited);
      checkOutput("ring2_addr", {2'b0, wr_burst_addr}, 32'd64);
      pulseAck();
      checkOutput("ring2_next", {2'b0, wr_burst_addr}, 32'd0);
      sendWords(16, 32'h600, 1'b0);
      waitReq(5, waited);
      checkOutput("ring3_req", {31'b0, wr_burst_req}, 32'd1);
      checkOutput("ring3_addr", {2'b0, wr_burst_addr}, 32'd0);
      pulseAck();
      sendWords(3, 32'h700, 1'b0);
      waitReq(TIMEOUT + 10, waited);
      checkOutput("ring_flush_len", {23'b0, wr_burst_len}, 32'd3);
      checkOutput("ring_flush_addr", {2'b0, wr_burst_addr}, 32'd64);
      pulseAck();
      checkOutput("ring_flush_next", {2'b0, wr_burst_addr}, 32'd0);

      $display("[TB] overflow and reset");
      doReset();
      applyStimulus(1'b1, 32'hDEAD, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("ovf_no_wr", {31'b0, fifo_wr_en}, 32'd0);
      checkOutput("ovf_set", {31'b0, overflow}, 32'd1);
      checkOutput("ovf_pending", 32'(dut.pending), 32'd0);
      sendWords(16, 32'h800, 1'b0);
      waitReq(5, waited);
      checkOutput("ovf_sticky", {31'b0, overflow}, 32'd1);
      checkOutput("ovf_req", {31'b0, wr_burst_req}, 32'd1);
      rst = 1'b1;
      tick();
      checkOutput("rst2_req", {31'b0, wr_burst_req}, 32'd0);
      checkOutput("rst2_len", {23'b0, wr_burst_len}, 32'd0);
      checkOutput("rst2_addr", {2'b0, wr_burst_addr}, 32'd0);
      checkOutput("rst2_ovf", {31'b0, overflow}, 32'd0);
      checkOutput("rst2_wr_en", {31'b0, fifo_wr_en}, 32'd0);
      checkOutput("rst2_wr_data", fifo_wr_data, 32'd0);
      checkOutput("rst2_pending", 32'(dut.pending), 32'd0);
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_ddr_wr_sched.md
# uart_ddr_wr_sched

Write scheduler between `uart_receiver` and the DDR3 write path. Forwards each 32-bit word from `uart_receiver` into the write FIFO and counts words that are buffered but not yet committed. It issues burst write requests (address and length) to the AXI write master once a full burst is buffered, or flushes a partial burst after a UART idle timeout. Byte addresses advance linearly through a ring region `[BASE_ADDR, END_ADDR)`.

## Interface
- `FIFO_WR_WIDTH`, 'd32: word width; must equal the `uart_receiver` FIFO_WR_WIDTH.
- `BURST_WORDS`, 'd16: words per full burst (power of 2, 1–256).
- `FIFO_DEPTH`, 'd512: write FIFO depth in words; sizes the pending counter.
- `ADDR_WIDTH`, 'd30: DDR byte-address width.
- `BASE_ADDR`, 'd0: ring start; must be aligned to BURST_WORDS*4.
- `END_ADDR`, 'd1_048_576: ring end, exclusive; (END_ADDR−BASE_ADDR) must be a multiple of BURST_WORDS*4.
- `TIMEOUT_CYC`, 'd104_160: idle cycles before a partial flush (2 byte-times at 9600 Bd / 50 MHz).
- `clk` in 1: single clock, same as the FIFO write clock.
- `rst` in 1: synchronous, active-high reset.
- `word_valid` in 1: one-cycle strobe from `uart_receiver` fifo_wr_en.
- `word_data` in FIFO_WR_WIDTH: word from `uart_receiver` fifo_wr_data.
- `fifo_full` in 1: write FIFO full flag.
- `fifo_wr_en` out 1: write FIFO write enable.
- `fifo_wr_data` out FIFO_WR_WIDTH: write FIFO data.
- `wr_burst_req` out 1: burst request; level, held until ack.
- `wr_burst_addr` out ADDR_WIDTH: burst start byte address; stable while req is high.
- `wr_burst_len` out 9: burst length in words (1..BURST_WORDS); stable while req is high.
- `wr_burst_ack` in 1: one-cycle pulse from the AXI master when the burst completes.
- `overflow` out 1: sticky; set when a word is dropped.

## Operation
- Forwarding:
  - Normally, `word_valid` with `fifo_full`=0 gives `fifo_wr_en`=1 and `fifo_wr_data`=`word_data` one cycle later.
  - If `fifo_full`=1 when `word_valid` arrives, the word is dropped: no write, `overflow` is set, and `pending` is unchanged.
- Counter: `pending` is clog2(FIFO_DEPTH+1) bits wide. It increments on each accepted word and decrements by `wr_burst_len` on ack.
  - On a simultaneous accept and ack, `pending` = `pending` + 1 − len.
  - It never wraps, because `fifo_full` bounds it.
- Idle counter:
  - Cleared on each `word_valid` and whenever `pending`=0.
  - Otherwise increments, saturating at TIMEOUT_CYC.
- FSM states:
  - COLLECT: go to REQ with len=BURST_WORDS when `pending`≥BURST_WORDS. Otherwise go to REQ with len=`pending` when the idle counter = TIMEOUT_CYC and `pending`>0.
  - REQ: `wr_burst_req`=1 and addr/len are latched. On ack, go to COLLECT and advance the address. Words keep being accepted and counted while in REQ.
- Address rule:
  - next = addr + len*4.
  - If next + BURST_WORDS*4 > END_ADDR, next = BASE_ADDR. A burst never crosses END_ADDR.
- Full-burst priority: in COLLECT, if both the full-burst and timeout conditions are true, issue a full burst.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_wr_data`=0, `wr_burst_req`=0, `wr_burst_addr`=BASE_ADDR, `wr_burst_len`=0, `overflow`=0. Internally, `pending`=0, idle counter=0, state=COLLECT.
- If `word_valid` is in cycle n, `fifo_wr_en` is high in cycle n+1 and `pending` is updated in cycle n+1.
- Request latency:
  - After a full burst: the BURST_WORDS-th accepted word strobe is in cycle n; `wr_burst_req` rises in cycle n+2.
  - After a timeout: the last strobe is in cycle n; req rises in cycle n+TIMEOUT_CYC+2.
- `wr_burst_req` falls the cycle after the ack. The earliest next req is 1 cycle after it falls, i.e. the cycle after COLLECT re-evaluates.
- An ack while not in REQ is ignored.
- Reset mid-burst abandons the request, and `pending` is lost. The FIFO must be reset together with this block.

## Structure
- Shared package `uart_ddr_pkg`:
  - FSM state encoding (COLLECT, REQ).
  - BYTES_PER_WORD = 4.
  - `wr_burst_len` width constant 9.
- One flat module; no sub-module. The idle timer is inline.

## Test plan
- 16 words 0x0000_0001..0x0000_0010 → 16 `fifo_wr_en` pulses with matching data, each one cycle after its strobe; req with addr=0, len=16, 2 cycles after the 16th strobe. Ack → `pending`=0, next addr=64.
- 5 words, then idle → req len=5, addr=0, exactly TIMEOUT_CYC+2 cycles after the 5th strobe. Ack → next addr=20.
- Words arriving during REQ:
  - 20 words back to back with the ack delayed 100 cycles → 4 words are counted during REQ.
  - After the ack, `pending`=4; a timeout flush then issues len=4 at addr=64.
- Word strobe in the same cycle as the ack → `pending` = old + 1 − len.
- Ring wrap: END_ADDR=128 with two full bursts (addr 0, 64) → third burst addr=0. A flush len=3 at addr 64 → next addr 76; since 76+64 > 128, it wraps to 0.
- `fifo_full`=1 during one strobe → no `fifo_wr_en` for that word, `overflow`=1 and stays set. `rst`=1 → `overflow`=0 and all outputs take their reset values.
